// File: rtl/runner_pkg.sv
// Shared encodings for the runner pipeline: heart-rate classification codes
// and alert state encoding, used by StepCalculator and the alert manager.
package runner_pkg;

   typedef enum logic [1:0] {
      CLS_SAFE    = 2'd0,
      CLS_WARN    = 2'd1,
      CLS_EMERG   = 2'd2,
      CLS_INVALID = 2'd3
   } hr_class_e;

   typedef enum logic [1:0] {
      ST_SAFE  = 2'd0,
      ST_WARN  = 2'd1,
      ST_EMERG = 2'd2,
      ST_ACKED = 2'd3
   } alert_state_e;

   localparam logic [7:0] EVENTS_MAX = 8'd255;

endpackage

// File: rtl/hr_alert_manager_if.sv
// Classification input and runner-facing alert outputs of the alert manager.
interface hr_alert_manager_if;

   logic [1:0] heart_rate_classification;
   logic       class_valid;
   logic       ack;
   logic [1:0] alert_level;
   logic       buzzer;
   logic [7:0] emergency_events;
   logic       sensor_fault;

   modport master (
      output heart_rate_classification, class_valid, ack,
      input  alert_level, buzzer, emergency_events, sensor_fault
   );

   modport slave (
      input  heart_rate_classification, class_valid, ack,
      output alert_level, buzzer, emergency_events, sensor_fault
   );

endinterface

// File: rtl/hr_buzzer_gen.sv
// Square-wave buzzer: high on the first enabled cycle, toggling every
// BUZZ_HALF cycles; restart re-phases, disable forces low immediately.
module hr_buzzer_gen #(
   parameter int unsigned BUZZ_HALF = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic buzzer
);

   localparam int unsigned CW = $clog2(BUZZ_HALF + 1);

   logic [CW-1:0] phase_r;
   logic          buzz_r;

   // phase counter and buzzer level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_r <= CW'(0);
         buzz_r  <= 1'b0;
      end else if (!enable) begin
         phase_r <= CW'(0);
         buzz_r  <= 1'b0;
      end else if (restart) begin
         phase_r <= CW'(0);
         buzz_r  <= 1'b1;
      end else if (phase_r == CW'(BUZZ_HALF - 1)) begin
         phase_r <= CW'(0);
         buzz_r  <= ~buzz_r;
      end else begin
         phase_r <= phase_r + CW'(1);
         buzz_r  <= buzz_r;
      end
   end

   assign buzzer = buzz_r;

endmodule

// File: rtl/hr_alert_manager.sv
// Confirms heart-rate classifications over consecutive samples, drives the
// alert level and buzzer, latches emergencies until acknowledged.
module hr_alert_manager
   import runner_pkg::*;
#(
   parameter int unsigned WARN_CONFIRM  = 3,
   parameter int unsigned EMERG_CONFIRM = 2,
   parameter int unsigned CLEAR_CONFIRM = 5,
   parameter int unsigned BUZZ_HALF     = 25
) (
   input logic              clk,
   input logic              rst,
   hr_alert_manager_if.slave bus
);

   localparam int unsigned WW = $clog2(WARN_CONFIRM + 1);
   localparam int unsigned EW = $clog2(EMERG_CONFIRM + 1);
   localparam int unsigned SW = $clog2(CLEAR_CONFIRM + 1);

   alert_state_e  state_r, next_state_s;
   logic [WW-1:0] warn_run_r, warn_run_nxt_s;
   logic [EW-1:0] emerg_run_r, emerg_run_nxt_s;
   logic [SW-1:0] safe_run_r, safe_run_nxt_s;
   logic [7:0]    emergency_events_r;
   logic          sensor_fault_r;

   logic sample_s, emerg_match_s, warn_match_s, safe_match_s;
   logic emerg_hit_s, warn_hit_s, safe_hit_s;
   logic state_change_s, emerg_enable_s, emerg_entry_s;

   assign sample_s      = bus.class_valid && (bus.heart_rate_classification != CLS_INVALID);
   assign emerg_match_s = (bus.heart_rate_classification == CLS_EMERG);
   assign warn_match_s  = (bus.heart_rate_classification == CLS_WARN) || emerg_match_s;
   assign safe_match_s  = (bus.heart_rate_classification == CLS_SAFE);

   // a hit is the sample that brings its run up to the confirm count
   assign emerg_hit_s = sample_s && emerg_match_s && (emerg_run_r == EW'(EMERG_CONFIRM - 1));
   assign warn_hit_s  = sample_s && warn_match_s  && (warn_run_r  == WW'(WARN_CONFIRM - 1));
   assign safe_hit_s  = sample_s && safe_match_s  && (safe_run_r  == SW'(CLEAR_CONFIRM - 1));

   assign state_change_s = (next_state_s != state_r);
   assign emerg_enable_s = (next_state_s == ST_EMERG);
   assign emerg_entry_s  = emerg_enable_s && (state_r != ST_EMERG);

   // next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_SAFE: begin
            if (emerg_hit_s)     next_state_s = ST_EMERG;
            else if (warn_hit_s) next_state_s = ST_WARN;
            else                 next_state_s = state_r;
         end
         ST_WARN, ST_ACKED: begin
            if (emerg_hit_s)     next_state_s = ST_EMERG;
            else if (safe_hit_s) next_state_s = ST_SAFE;
            else                 next_state_s = state_r;
         end
         ST_EMERG: begin
            if (bus.ack) next_state_s = ST_ACKED;
            else         next_state_s = state_r;
         end
         default: next_state_s = ST_SAFE;
      endcase
   end

   // saturating run counters; invalid or absent samples hold, state changes clear
   always_comb begin
      warn_run_nxt_s  = warn_run_r;
      emerg_run_nxt_s = emerg_run_r;
      safe_run_nxt_s  = safe_run_r;
      if (state_change_s) begin
         warn_run_nxt_s  = WW'(0);
         emerg_run_nxt_s = EW'(0);
         safe_run_nxt_s  = SW'(0);
      end else if (sample_s) begin
         emerg_run_nxt_s = emerg_match_s ? ((emerg_run_r == EW'(EMERG_CONFIRM)) ? emerg_run_r
                                            : emerg_run_r + EW'(1)) : EW'(0);
         warn_run_nxt_s  = warn_match_s ? ((warn_run_r == WW'(WARN_CONFIRM)) ? warn_run_r
                                            : warn_run_r + WW'(1)) : WW'(0);
         safe_run_nxt_s  = safe_match_s ? ((safe_run_r == SW'(CLEAR_CONFIRM)) ? safe_run_r
                                            : safe_run_r + SW'(1)) : SW'(0);
      end else begin
         warn_run_nxt_s  = warn_run_r;
         emerg_run_nxt_s = emerg_run_r;
         safe_run_nxt_s  = safe_run_r;
      end
   end

   // state, run counters, event counter and sticky fault
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r            <= ST_SAFE;
         warn_run_r         <= WW'(0);
         emerg_run_r        <= EW'(0);
         safe_run_r         <= SW'(0);
         emergency_events_r <= 8'd0;
         sensor_fault_r     <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         warn_run_r  <= warn_run_nxt_s;
         emerg_run_r <= emerg_run_nxt_s;
         safe_run_r  <= safe_run_nxt_s;
         if (emerg_entry_s && (emergency_events_r != EVENTS_MAX))
            emergency_events_r <= emergency_events_r + 8'd1;
         else
            emergency_events_r <= emergency_events_r;
         if (bus.class_valid && (bus.heart_rate_classification == CLS_INVALID))
            sensor_fault_r <= 1'b1;
         else
            sensor_fault_r <= sensor_fault_r;
      end
   end

   hr_buzzer_gen #(
      .BUZZ_HALF (BUZZ_HALF)
   ) u_buzzer (
      .clk     (clk),
      .rst     (rst),
      .enable  (emerg_enable_s),
      .restart (emerg_entry_s),
      .buzzer  (bus.buzzer)
   );

   assign bus.alert_level      = state_r;
   assign bus.emergency_events = emergency_events_r;
   assign bus.sensor_fault     = sensor_fault_r;

endmodule

// File: tb/tb_hr_alert_manager.sv
// Directed vectors for hr_alert_manager with hand-computed expectations.
module tb_hr_alert_manager;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   hr_alert_manager_if bus_if ();

   hr_alert_manager dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one class_valid pulse; returns on the falling edge after it is captured
   task automatic send(input logic [1:0] cls);
      @(negedge clk);
      bus_if.heart_rate_classification = cls;
      bus_if.class_valid = 1'b1;
      @(negedge clk);
      bus_if.class_valid = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      bus_if.ack = 1'b1;
      @(negedge clk);
      bus_if.ack = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      bus_if.heart_rate_classification = 2'd0;
      bus_if.class_valid = 1'b0;
      bus_if.ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_level", bus_if.alert_level, 0);
      check("rst_buzzer", bus_if.buzzer, 0);
      check("rst_events", bus_if.emergency_events, 0);
      check("rst_fault", bus_if.sensor_fault, 0);

      // Warning run broken by a Safe sample
      send(2'b01); send(2'b01); send(2'b00); send(2'b01); send(2'b01);
      check("warn_broken", bus_if.alert_level, 0);
      send(2'b01);
      check("warn_enter", bus_if.alert_level, 1);
      for (int i = 0; i < 4; i++) send(2'b00);
      check("warn_4safe", bus_if.alert_level, 1);
      send(2'b00);
      check("warn_clear", bus_if.alert_level, 0);

      // non-valid cycles are ignored
      @(negedge clk);
      bus_if.heart_rate_classification = 2'b10;
      repeat (4) @(negedge clk);
      check("novalid_level", bus_if.alert_level, 0);

      // emergency from SAFE and buzzer waveform
      send(2'b10);
      check("emerg_one", bus_if.alert_level, 0);
      send(2'b10);
      check("emerg_enter", bus_if.alert_level, 2);
      check("emerg_events1", bus_if.emergency_events, 1);
      check("buzz_c0", bus_if.buzzer, 1);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         check("buzz_wave", bus_if.buzzer, ((i / 25) % 2 == 0) ? 1 : 0);
      end

      // samples never leave EMERG; ack with a simultaneous sample wins
      for (int i = 0; i < 8; i++) send(2'b00);
      check("emerg_hold", bus_if.alert_level, 2);
      @(negedge clk);
      bus_if.ack = 1'b1;
      bus_if.class_valid = 1'b1;
      bus_if.heart_rate_classification = 2'b00;
      @(negedge clk);
      bus_if.ack = 1'b0;
      bus_if.class_valid = 1'b0;
      check("acked_level", bus_if.alert_level, 3);
      check("acked_buzzer", bus_if.buzzer, 0);
      for (int i = 0; i < 4; i++) send(2'b00);
      check("acked_4safe", bus_if.alert_level, 3);
      send(2'b00);
      check("acked_clear", bus_if.alert_level, 0);

      pulse_ack();
      check("ack_ignored", bus_if.alert_level, 0);

      // re-entry from ACKED counts a new event and restarts the buzzer
      send(2'b10); send(2'b10);
      check("emerg2_level", bus_if.alert_level, 2);
      check("emerg2_events", bus_if.emergency_events, 2);
      pulse_ack();
      check("acked2_level", bus_if.alert_level, 3);
      send(2'b10);
      check("acked2_one", bus_if.alert_level, 3);
      send(2'b10);
      check("reenter_level", bus_if.alert_level, 2);
      check("reenter_events", bus_if.emergency_events, 3);
      check("reenter_buzz", bus_if.buzzer, 1);
      pulse_ack();
      for (int i = 0; i < 5; i++) send(2'b00);
      check("back_safe", bus_if.alert_level, 0);

      // invalid sample holds the runs and sets the sticky fault
      send(2'b01); send(2'b01); send(2'b11);
      check("fault_set", bus_if.sensor_fault, 1);
      check("fault_level", bus_if.alert_level, 0);
      send(2'b01);
      check("fault_warn", bus_if.alert_level, 1);
      for (int i = 0; i < 5; i++) send(2'b00);
      check("fault_sticky_lvl", bus_if.alert_level, 0);
      check("fault_sticky", bus_if.sensor_fault, 1);

      // event counter saturation
      send(2'b10); send(2'b10);
      check("sat_start", bus_if.emergency_events, 4);
      for (int i = 0; i < 251; i++) begin
         pulse_ack();
         send(2'b10); send(2'b10);
      end
      check("sat_255", bus_if.emergency_events, 255);
      check("sat_level", bus_if.alert_level, 2);
      pulse_ack();
      send(2'b10); send(2'b10);
      check("sat_hold", bus_if.emergency_events, 255);
      check("sat_buzz", bus_if.buzzer, 1);

      // asynchronous reset mid-EMERG
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_level", bus_if.alert_level, 0);
      check("arst_buzzer", bus_if.buzzer, 0);
      check("arst_events", bus_if.emergency_events, 0);
      check("arst_fault", bus_if.sensor_fault, 0);
      @(negedge clk);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
